// File: rtl/ping_pkg.sv
// ping_pkg: shared definitions for the single-pin ultrasonic ranger.
//   - ping_state_e : FSM state encoding (also exported on the debug port)
//   - DEF_*        : default timing constants for a 50 MHz clock
//   - NO_OBJECT    : all-ones distance code for "no echo / timeout"
//   - us_to_mm()   : echo width (us) to distance (mm), 32-bit product >> 16
package ping_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIGGER = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_LISTEN  = 3'd3,
    ST_ECHO    = 3'd4,
    ST_CALC    = 3'd5,
    ST_WAIT    = 3'd6
  } ping_state_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_CLKS_PER_US = 50;
  localparam int DEF_TRIG_US     = 5;
  localparam int DEF_HOLDOFF_US  = 750;
  localparam int DEF_TIMEOUT_US  = 18500;
  localparam int DEF_PERIOD_US   = 20000;
  localparam int DEF_MM_SCALE    = 11239;

  // Width of the us counter; bounds TIMEOUT_US to 65535.
  localparam int US_W = 16;

  // Truncated to WIDTH bits at the use site, so it is all-ones for any WIDTH <= 32.
  localparam logic [31:0] NO_OBJECT = 32'hFFFF_FFFF;

  function automatic logic [31:0] us_to_mm(input logic [US_W-1:0] us,
                                           input logic [31:0]     scale);
    logic [31:0] prod;
    prod = 32'(us) * scale;
    return prod >> 16;
  endfunction

endpackage

// File: rtl/ping_us_timer.sv
// ping_us_timer: microsecond prescaler plus clearable, saturating us counter.
//   clk, reset : system clock, synchronous active-high reset
//   clr_i      : restart the interval; the cycle asserting clr_i counts as the
//                first clock of the new interval, so us_o reaches N exactly
//                N*CLKS_PER_US clocks after the clearing cycle
//   us_o       : whole microseconds elapsed in the current interval
// CLKS_PER_US must be >= 2.
module ping_us_timer import ping_pkg::*; #(
  parameter int CLKS_PER_US = DEF_CLKS_PER_US
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  output logic [US_W-1:0] us_o
);

  localparam int            PW   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_US - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic [US_W-1:0] us_q, us_d;
  logic            tick;

  always_comb begin
    tick    = (presc_q == PMAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    us_d    = (tick && (us_q != '1)) ? us_q + 1'b1 : us_q;
    if (clr_i) begin
      presc_d = PW'(1);
      us_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      us_q    <= '0;
    end else begin
      presc_q <= presc_d;
      us_q    <= us_d;
    end
  end

  assign us_o = us_q;

endmodule

// File: rtl/ping.sv
// ping: controller for a PING-style ultrasonic sensor sharing one pin for
// trigger and echo. Each period it drives a trigger pulse, holds the pin low,
// releases it, times the echo and converts the width to millimetres.
//   clk, reset : 50 MHz system clock, synchronous active-high reset
//   sensor     : bidirectional pin; driven while listening=0, high-Z otherwise
//   distance   : last distance in mm, all-ones on no echo / echo timeout
//   listening  : 1 while the pin is released (LISTEN, ECHO)
//   state      : current FSM state (debug)
//   valid      : (only with PING_VALID_EN defined) one-cycle pulse in the
//                first cycle a new distance value is visible
module ping import ping_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CLKS_PER_US = DEF_CLKS_PER_US,
  parameter int TRIG_US     = DEF_TRIG_US,
  parameter int HOLDOFF_US  = DEF_HOLDOFF_US,
  parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int PERIOD_US   = DEF_PERIOD_US,
  parameter int MM_SCALE    = DEF_MM_SCALE
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire              sensor,
  output logic [WIDTH-1:0] distance,
  output logic             listening,
  output logic [2:0]       state
`ifdef PING_VALID_EN
  ,
  output logic             valid
`endif
);

  localparam logic [US_W-1:0] TRIG_T   = US_W'(TRIG_US);
  localparam logic [US_W-1:0] HOLD_T   = US_W'(HOLDOFF_US);
  localparam logic [US_W-1:0] TMO_T    = US_W'(TIMEOUT_US);
  localparam logic [31:0]     PER_LAST = 32'(PERIOD_US * CLKS_PER_US - 1);

  ping_state_e      st_q, st_d;
  logic [WIDTH-1:0] dist_q, dist_d;
  logic [US_W-1:0]  echo_q, echo_d;
  logic [31:0]      per_q, per_d;
  logic             armed_q, armed_d;
  logic             s1_q, s2_q;
  logic [1:0]       svld_q;
  logic             upd;
  logic [US_W-1:0]  us_cnt;
  logic             tmr_clr;

  // Restart the us interval on every state change.
  assign tmr_clr = (st_d != st_q);

  ping_us_timer #(.CLKS_PER_US(CLKS_PER_US)) u_tmr (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .us_o  (us_cnt)
  );

  assign listening = (st_q == ST_LISTEN) || (st_q == ST_ECHO);
  assign sensor    = listening ? 1'bz : (st_q == ST_TRIGGER);
  assign distance  = dist_q;
  assign state     = st_q;

  always_comb begin
    st_d    = st_q;
    dist_d  = dist_q;
    echo_d  = echo_q;
    armed_d = armed_q;
    upd     = 1'b0;
    case (st_q)
      ST_IDLE:    st_d = ST_TRIGGER;
      ST_TRIGGER: if (us_cnt == TRIG_T) st_d = ST_HOLDOFF;
      ST_HOLDOFF: if (us_cnt == HOLD_T) st_d = ST_LISTEN;
      ST_LISTEN: begin
        // A rise only counts after a low has been seen on valid synced
        // samples, so an echo already high at release is ignored.
        if (svld_q[1] && !s2_q) armed_d = 1'b1;
        if (armed_q && s2_q) begin
          st_d = ST_ECHO;
        end else if (us_cnt == TMO_T) begin
          st_d   = ST_WAIT;
          dist_d = WIDTH'(NO_OBJECT);
          upd    = 1'b1;
        end
      end
      ST_ECHO: begin
        if (!s2_q) begin
          st_d   = ST_CALC;
          echo_d = us_cnt;
        end else if (us_cnt == TMO_T) begin
          st_d   = ST_WAIT;
          dist_d = WIDTH'(NO_OBJECT);
          upd    = 1'b1;
        end
      end
      ST_CALC: begin
        dist_d = WIDTH'(us_to_mm(echo_q, 32'(MM_SCALE)));
        upd    = 1'b1;
        st_d   = ST_WAIT;
      end
      // >= so an echo timeout running past the period boundary still retriggers.
      ST_WAIT:    if (per_q >= PER_LAST) st_d = ST_TRIGGER;
      default:    st_d = ST_IDLE;
    endcase
    if (st_q != ST_LISTEN) armed_d = 1'b0;
  end

  // Period counter in clocks, zero in the first TRIGGER cycle.
  always_comb begin
    per_d = (per_q != '1) ? per_q + 32'd1 : per_q;
    if (st_d == ST_TRIGGER && st_q != ST_TRIGGER) per_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      dist_q  <= '0;
      echo_q  <= '0;
      per_q   <= '0;
      armed_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      svld_q  <= '0;
    end else begin
      st_q    <= st_d;
      dist_q  <= dist_d;
      echo_q  <= echo_d;
      per_q   <= per_d;
      armed_q <= armed_d;
      // Pin is only sampled while released; svld_q marks when s2_q holds a
      // real pin sample rather than the forced-low fill.
      s1_q    <= listening ? sensor : 1'b0;
      s2_q    <= s1_q;
      svld_q  <= {svld_q[0], listening};
    end
  end

`ifdef PING_VALID_EN
  logic valid_q;
  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= upd;
  end
  assign valid = valid_q;
`else
  logic unused_upd;
  assign unused_upd = upd;
`endif

endmodule

// File: tb/tb_ping.sv
// tb_ping: self-checking bench for ping with time-scaled parameters
// (2 clocks per us, 2000 us period) so a full run stays short.
module tb_ping;
  localparam int CLKS = 2, TRIG = 5, HOLD = 75, TMO = 1850, PER = 2000, MMS = 11239;
  localparam int PER_CYC = PER * CLKS;

  logic clk = 1'b0, reset = 1'b1, echo_lvl = 1'b0;
  wire  sensor;
  logic [15:0] distance;
  logic        listening;
  logic [2:0]  state;
`ifdef PING_VALID_EN
  logic        valid;
`endif

  // The sensor answers only while the controller has released the pin.
  assign sensor = listening ? echo_lvl : 1'bz;

  ping #(.WIDTH(16), .CLKS_PER_US(CLKS), .TRIG_US(TRIG), .HOLDOFF_US(HOLD),
         .TIMEOUT_US(TMO), .PERIOD_US(PER), .MM_SCALE(MMS)) dut (
    .clk       (clk),
    .reset     (reset),
    .sensor    (sensor),
    .distance  (distance),
    .listening (listening),
    .state     (state)
`ifdef PING_VALID_EN
    ,
    .valid     (valid)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Observation of trigger starts, trigger pulse width and pin release time.
  int cyc = 0, trig_cnt = 0, trig_cyc = 0, trig_prev = 0, lis_cyc = 0;
  int hi_cnt = 0, hi_last = 0, vld_cnt = 0, vld_last = 0;
  logic [2:0] prev_st = 3'd0, pre_trig_st = 3'd0;
  logic       prev_lis = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_st  <= state;
    prev_lis <= listening;
    if (listening && !prev_lis) lis_cyc <= cyc;
    if (state == 3'd1 && prev_st != 3'd1) begin
      trig_cnt    <= trig_cnt + 1;
      trig_prev   <= trig_cyc;
      trig_cyc    <= cyc;
      pre_trig_st <= prev_st;
      hi_last     <= hi_cnt;
      hi_cnt      <= (sensor == 1'b1) ? 1 : 0;
      vld_last    <= vld_cnt;
      vld_cnt     <= 0;
    end else begin
      if (!listening && sensor == 1'b1) hi_cnt <= hi_cnt + 1;
`ifdef PING_VALID_EN
      if (valid) vld_cnt <= vld_cnt + 1;
`endif
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: distance from echo width in whole microseconds.
  function automatic int model_mm(input int w_us);
    longint p;
    if (w_us > TMO) return 65535;
    p = longint'(w_us) * MMS;
    return int'(p / 65536);
  endfunction

  task automatic wait_trig(input int n0, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < PER_CYC + 200) begin
      @(negedge clk); #1;
      ok = (trig_cnt != n0);
      i++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL trigger wait: none within %0d cycles", PER_CYC + 200);
    end
  endtask

  task automatic finish_meas(input int n0, input int exp, input string nm);
    bit ok;
    wait_trig(n0, ok);
    if (ok) begin
      chk({nm, " distance"}, distance, exp);
      chk({nm, " period"}, trig_cyc - trig_prev, PER_CYC);
      chk({nm, " state before trigger"}, pre_trig_st, 6);
      chk({nm, " trigger width"}, hi_last, TRIG * CLKS);
      chk({nm, " release offset"}, lis_cyc - trig_prev, (TRIG + HOLD) * CLKS);
`ifdef PING_VALID_EN
      chk({nm, " valid pulses"}, vld_last, 1);
`endif
    end
  endtask

  // Called at a trigger start; w_us = 0 means no echo at all.
  task automatic apply_echo(input int rise_us, input int w_us, input int exp, input string nm);
    int n0;
    n0 = trig_cnt;
    if (w_us > 0) begin
      repeat (rise_us * CLKS) @(negedge clk);
      echo_lvl = 1'b1;
      repeat (w_us * CLKS) @(negedge clk);
      echo_lvl = 1'b0;
    end
    finish_meas(n0, exp, nm);
  endtask

  typedef struct {
    int    rise_us;
    int    w_us;
    int    exp;
    string nm;
  } vec_t;

  vec_t tab[6];

  initial begin
    bit ok;
    int n0, r, w;
    tab[0] = '{300, 500,  85,    "echo 500us"};
    tab[1] = '{500, 1000, 171,   "echo 1000us"};
    tab[2] = '{0,   0,    65535, "no echo"};
    tab[3] = '{100, 1870, 65535, "echo too long"};
    tab[4] = '{200, 6,    1,     "echo 6us"};
    tab[5] = '{200, 5,    0,     "echo 5us"};

    repeat (10) @(negedge clk);
    chk("reset state", state, 0);
    chk("reset distance", distance, 0);
    chk("reset listening", listening, 0);
    chk("reset sensor", sensor, 0);
    n0 = trig_cnt;
    reset = 1'b0;
    wait_trig(n0, ok);
    chk("state after release", state, 1);
    chk("trigger starts 1 cycle after release", trig_cnt - n0, 1);

    foreach (tab[i]) apply_echo(tab[i].rise_us, tab[i].w_us, tab[i].exp, tab[i].nm);

    // Echo already high when the pin is released: must fall and rise again.
    n0 = trig_cnt;
    echo_lvl = 1'b1;
    repeat (150 * CLKS) @(negedge clk);
    echo_lvl = 1'b0;
    repeat (50 * CLKS) @(negedge clk);
    echo_lvl = 1'b1;
    repeat (300 * CLKS) @(negedge clk);
    echo_lvl = 1'b0;
    finish_meas(n0, model_mm(300), "high at release");

    for (int k = 0; k < 4; k++) begin
      r = int'($urandom_range(400, 90));
      w = int'($urandom_range(1500, 20));
      apply_echo(r, w, model_mm(w), $sformatf("random %0d w=%0d", k, w));
    end

    // Reset while timing an echo.
    repeat (200 * CLKS) @(negedge clk);
    echo_lvl = 1'b1;
    repeat (100 * CLKS) @(negedge clk);
    chk("in echo before reset", state, 4);
    reset = 1'b1;
    @(negedge clk);
    chk("reset in echo state", state, 0);
    chk("reset in echo distance", distance, 0);
    chk("reset in echo listening", listening, 0);
    chk("reset in echo sensor", sensor, 0);
    echo_lvl = 1'b0;
    n0 = trig_cnt;
    reset = 1'b0;
    wait_trig(n0, ok);
    chk("restart state", state, 1);
    apply_echo(500, 1000, model_mm(1000), "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
